mul_arbiter: RTL

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_arbiter_if.sv | 25 ++
 rtl/mul_rr_pick.sv | 11 +
 rtl/mul_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the two-requester multiplier arbiter.
package mul_pkg;
    localparam int OP_W        = 8;
    localparam int RES_W       = 16;
    localparam int CNT_W       = 4;
    localparam int MUL_LAT_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_e;
endpackage

// File: rtl/mul_arbiter_if.sv
// Requester, result and multiplier-datapath signals of mul_arbiter.
interface mul_arbiter_if;
    import mul_pkg::*;

    logic             req0, req1;
    logic [OP_W-1:0]  a0, b0, a1, b1;
    logic             gnt0, gnt1;
    logic             res_valid, res_ready;
    logic [RES_W-1:0] res;
    logic             res_id;
    logic             mul_st;
    logic [OP_W-1:0]  mul_a, mul_b;
    logic [RES_W-1:0] mul_answer;
    logic             busy;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, res_ready, mul_answer,
        output gnt0, gnt1, res_valid, res, res_id, mul_st, mul_a, mul_b, busy
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, res_ready, mul_answer,
        input  gnt0, gnt1, res_valid, res, res_id, mul_st, mul_a, mul_b, busy
    );
endinterface

// File: rtl/mul_rr_pick.sv
// Combinational 2-way round-robin picker: on contention the side that did not win last time wins.
module mul_rr_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_gnt_i,
    output logic valid_o,
    output logic id_o
);
    assign valid_o = req0_i | req1_i;
    assign id_o    = (req0_i & req1_i) ? ~last_gnt_i : req1_i;
endmodule

// File: rtl/mul_arbiter.sv
// Shares one fixed-latency 8x8 multiplier between two requesters; one transaction in flight at a time.
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mul_arbiter_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MUL_LAT);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RES_W-1:0] res_q, res_d;
    logic             pick_vld, pick_id;

    mul_rr_pick u_pick (
        .req0_i     (bus.req0),
        .req1_i     (bus.req1),
        .last_gnt_i (last_q),
        .valid_o    (pick_vld),
        .id_o       (pick_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (pick_vld) begin
                id_d    = pick_id;
                last_d  = pick_id;
                a_d     = pick_id ? bus.a1 : bus.a0;
                b_d     = pick_id ? bus.b1 : bus.b0;
                state_d = START;
            end
            START: begin
                cnt_d   = LAT_C;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // cnt_q==1 marks the final WAIT cycle, where the datapath answer is valid
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = bus.mul_answer;
                    state_d = HOLD;
                end
            end
            HOLD: if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic in_start, in_op, in_hold;
    assign in_start = (state_q == START);
    assign in_op    = (state_q == START) || (state_q == WAIT);
    assign in_hold  = (state_q == HOLD);

    assign bus.mul_st    = in_start;
    assign bus.gnt0      = in_start & ~id_q;
    assign bus.gnt1      = in_start &  id_q;
    assign bus.mul_a     = in_op ? a_q : '0;
    assign bus.mul_b     = in_op ? b_q : '0;
    assign bus.res_valid = in_hold;
    assign bus.res       = in_hold ? res_q : '0;
    assign bus.res_id    = in_hold & id_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
